// File: rtl/rv32i_types.sv
// Shared types for branch-prediction bookkeeping: BHR width and the checkpoint
// record saved for every in-flight conditional-branch prediction.
package rv32i_types;

    localparam int BHR_W = 4;

    typedef struct packed {
        logic [BHR_W-1:0] index;
        logic [BHR_W-1:0] bhr;
        logic             taken;
    } bp_ckpt_t;

    // PHT index is the gshare-style hash of the history with PC word bits [5:2].
    function automatic logic [BHR_W-1:0] ckpt_index(input logic [31:0] pc,
                                                    input logic [BHR_W-1:0] bhr);
        return bhr ^ pc[5:2];
    endfunction

endpackage

// File: rtl/bp_update_ctrl_fifo.sv
// In-order checkpoint FIFO (module bp_ckpt_fifo): one slot per outstanding prediction.
// clear empties the FIFO and takes priority over a push in the same cycle.
module bp_ckpt_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  bp_ckpt_t push_data,
    input  logic     pop,
    input  logic     clear,
    output logic     full,
    output logic     empty,
    output bp_ckpt_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    bp_ckpt_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// Branch-predictor update controller: checkpoints predictions, trains the PHT on
// resolution and squashes/restores history on mispredict. Optional macro: BP_UPDATE_STATS_EN.
//
// state    | meaning
// RUN      | accepting predictions and resolutions
// RECOVER  | one-cycle bubble after a mispredict flush
module bp_update_ctrl
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_valid,
    input  logic [31:0]      pred_pc,
    input  logic [BHR_W-1:0] pred_bhr,
    input  logic             pred_taken,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    output logic             pht_write,
    output logic [BHR_W-1:0] pht_index,
    output logic             pht_taken,
    output logic             bhr_restore,
    output logic [BHR_W-1:0] bhr_restore_val,
`ifdef BP_UPDATE_STATS_EN
    output logic [31:0]      branch_cnt,
    output logic [31:0]      mispredict_cnt,
`endif
    output logic             flush
);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_RECOVER = 1'b1;

    logic [0:0] state;
    logic       fifo_full;
    logic       fifo_empty;
    bp_ckpt_t   head;
    bp_ckpt_t   new_ckpt;
    logic       do_push;
    logic       do_pop;
    logic       mispredict;

    assign pred_ready = !fifo_full && (state == ST_RUN);
    assign do_pop     = res_valid && !fifo_empty && (state == ST_RUN);
    assign mispredict = do_pop && (head.taken != res_taken);
    assign do_push    = pred_valid && pred_ready && !mispredict;

    assign new_ckpt.index = ckpt_index(pred_pc, pred_bhr);
    assign new_ckpt.bhr   = pred_bhr;
    assign new_ckpt.taken = pred_taken;

    bp_ckpt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (do_push),
        .push_data (new_ckpt),
        .pop       (do_pop),
        .clear     (mispredict),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_RUN;
            pht_write       <= 1'b0;
            pht_index       <= '0;
            pht_taken       <= 1'b0;
            bhr_restore     <= 1'b0;
            bhr_restore_val <= '0;
            flush           <= 1'b0;
        end else begin
            pht_write   <= do_pop;
            bhr_restore <= mispredict;
            flush       <= mispredict;
            if (do_pop) begin
                pht_index <= head.index;
                pht_taken <= res_taken;
            end
            // Corrected history: shift the real outcome in after the checkpointed BHR.
            if (mispredict) bhr_restore_val <= {head.bhr[BHR_W-2:0], res_taken};
            case (state)
                ST_RUN:     state <= mispredict ? ST_RECOVER : ST_RUN;
                ST_RECOVER: state <= ST_RUN;
                default:    state <= ST_RUN;
            endcase
        end
    end

`ifdef BP_UPDATE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (do_pop)     branch_cnt     <= branch_cnt + 32'd1;
            if (mispredict) mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Self-checking bench for bp_update_ctrl: directed scenarios then randomized traffic
// against a queue-based reference model.
module tb_bp_update_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc = '0;
    logic [3:0]  pred_bhr = '0;
    logic        pred_taken = 1'b0;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic        pred_ready;
    logic        pht_write;
    logic [3:0]  pht_index;
    logic        pht_taken;
    logic        bhr_restore;
    logic [3:0]  bhr_restore_val;
    logic        flush;
`ifdef BP_UPDATE_STATS_EN
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;
`endif

    bp_update_ctrl #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pred_valid      (pred_valid),
        .pred_pc         (pred_pc),
        .pred_bhr        (pred_bhr),
        .pred_taken      (pred_taken),
        .pred_ready      (pred_ready),
        .res_valid       (res_valid),
        .res_taken       (res_taken),
        .pht_write       (pht_write),
        .pht_index       (pht_index),
        .pht_taken       (pht_taken),
        .bhr_restore     (bhr_restore),
        .bhr_restore_val (bhr_restore_val),
`ifdef BP_UPDATE_STATS_EN
        .branch_cnt      (branch_cnt),
        .mispredict_cnt  (mispredict_cnt),
`endif
        .flush           (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned idx;
        int unsigned bhr;
        bit          tk;
    } ent_t;

    ent_t        q[$];
    bit          m_rec;
    bit          m_known;
    bit          e_write;
    bit          e_flush;
    int unsigned e_idx;
    bit          e_tk;
    int unsigned e_val;
    logic [31:0] e_bcnt;
    logic [31:0] e_mcnt;
    int          n_checks;
    int          n_errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, check outputs just after the edge.
    task automatic cycle(input bit pv, input logic [31:0] pc, input logic [3:0] bhr,
                         input bit pt, input bit rv, input bit rt, input bit rn);
        bit   ready;
        bit   pop;
        bit   misp;
        ent_t h;
        ent_t n;
        pred_valid = pv; pred_pc = pc; pred_bhr = bhr; pred_taken = pt;
        res_valid = rv; res_taken = rt; rst_n = rn;
        ready = !m_rec && (q.size() < DEPTH);
        if (m_known) chk("pred_ready", pred_ready, ready);
        e_write = 0;
        e_flush = 0;
        if (!rn) begin
            q.delete();
            m_rec  = 0;
            e_bcnt = 0;
            e_mcnt = 0;
        end else begin
            pop  = rv && (q.size() > 0) && !m_rec;
            misp = 0;
            if (pop) begin
                h       = q.pop_front();
                e_write = 1;
                e_idx   = h.idx;
                e_tk    = rt;
                e_bcnt  = e_bcnt + 1;
                if (h.tk != rt) begin
                    misp    = 1;
                    e_flush = 1;
                    e_mcnt  = e_mcnt + 1;
                    e_val   = ((h.bhr * 2) + rt) % 16;
                end
            end
            if (misp) begin
                q.delete();
                m_rec = 1;
            end else begin
                m_rec = 0;
                if (pv && ready) begin
                    n.idx = (bhr ^ (pc / 4)) % 16;
                    n.bhr = bhr;
                    n.tk  = pt;
                    q.push_back(n);
                end
            end
        end
        @(posedge clk);
        #1;
        m_known = 1;
        chk("pht_write", pht_write, e_write);
        chk("flush", flush, e_flush);
        chk("bhr_restore", bhr_restore, e_flush);
        if (e_write) begin
            chk("pht_index", pht_index, e_idx);
            chk("pht_taken", pht_taken, e_tk);
        end
        if (e_flush) chk("bhr_restore_val", bhr_restore_val, e_val);
        if (!rn) begin
            chk("rst_pht_index", pht_index, 0);
            chk("rst_pht_taken", pht_taken, 0);
            chk("rst_bhr_val", bhr_restore_val, 0);
        end
`ifdef BP_UPDATE_STATS_EN
        chk("branch_cnt", branch_cnt, e_bcnt);
        chk("mispredict_cnt", mispredict_cnt, e_mcnt);
`endif
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_known  = 0;
        m_rec    = 0;
        e_bcnt   = 0;
        e_mcnt   = 0;

        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("reset_ready", pred_ready, 1);

        // Correct prediction trains the PHT without a flush.
        cycle(1, 32'h0000_0014, 4'b0011, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 1, 1);
        chk("t1_write", pht_write, 1);
        chk("t1_index", pht_index, 4'b0110);
        chk("t1_taken", pht_taken, 1);
        chk("t1_flush", flush, 0);
        idle();

        // Mispredict on the oldest of three entries.
        cycle(1, 32'h0, 4'b1010, 0, 0, 0, 1);
        cycle(1, 32'h104, 4'b0001, 1, 0, 0, 1);
        cycle(1, 32'h208, 4'b0111, 0, 0, 0, 1);
        cycle(1, 32'h30c, 4'b1111, 1, 1, 1, 1);
        chk("t2_flush", flush, 1);
        chk("t2_restore_val", bhr_restore_val, 4'b0101);
        chk("t2_ready_low", pred_ready, 0);
        idle();
        chk("t2_ready_back", pred_ready, 1);
        cycle(0, 0, 0, 0, 1, 0, 1);
        chk("t2_empty_no_write", pht_write, 0);

        // Fill to capacity, then push+pop while full.
        for (int i = 0; i < DEPTH; i++) cycle(1, 32'(i * 4), 4'(i), 1, 0, 0, 1);
        chk("t3_full", pred_ready, 0);
        cycle(1, 32'h40, 4'h9, 0, 1, 1, 1);
        cycle(1, 32'h44, 4'h3, 1, 1, 1, 1);
        cycle(1, 32'h48, 4'h5, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 0, 1, 1, 1);

        // Resolve with nothing outstanding.
        cycle(0, 0, 0, 0, 1, 1, 1);
        chk("t4_no_write", pht_write, 0);
        chk("t4_no_flush", flush, 0);

        // Reset overlapping a mispredicting resolve.
        for (int i = 0; i < 3; i++) cycle(1, 32'(i * 8), 4'(i + 2), 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 1, 0);
        chk("t5_no_flush", flush, 0);
        idle();
        chk("t5_ready", pred_ready, 1);
        cycle(0, 0, 0, 0, 1, 0, 1);
        chk("t5_empty", pht_write, 0);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, 4'($urandom),
                  1'($urandom), $urandom_range(0, 9) < 4, 1'($urandom),
                  $urandom_range(0, 99) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
